// File: rtl/rca_share_arbiter_pkg.sv
// Shared types and constants for the RCA share arbiter slice.
package rca_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam int unsigned NREQ  = 2;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned OP_W  = 16;

endpackage

// File: rtl/RCA_16bit.sv
// 16-bit ripple-carry adder built from a chain of full-adder cells.
module RCA_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum,
   output logic        cout
);

   // Carry ripples bit by bit through a block-local variable.
   always_comb begin
      logic c;
      c   = cin;
      sum = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/rca_share_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant: prio picks the winner on a tie.
module rr_arb2
   import rca_arb_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic            prio,
   output logic [NREQ-1:0] gnt
);

   // One-hot grant; a lone requester always wins, a tie goes to prio.
   always_comb begin
      gnt = '0;
      if (req == 2'b11) begin
         gnt = prio ? 2'b10 : 2'b01;
      end else begin
         gnt = req;
      end
   end

endmodule

// File: rtl/rca_share_arbiter.sv
// Shares one ripple-carry adder between two requesters with round-robin
// arbitration; operands are held for SETTLE_CYCLES clocks before capture.
module rca_share_arbiter
   import rca_arb_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 24
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*OP_W-1:0] req_a,
   input  logic [NREQ*OP_W-1:0] req_b,
   input  logic [NREQ-1:0]      req_cin,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic                 rsp_id,
   output logic [OP_W-1:0]      rsp_sum,
   output logic                 rsp_cout,
   output logic                 busy
);

   state_t           state;
   logic             prio;
   logic [OP_W-1:0]  op_a;
   logic [OP_W-1:0]  op_b;
   logic             op_cin;
   logic [CNT_W-1:0] cnt;
   logic [NREQ-1:0]  gnt;
   logic [OP_W-1:0]  add_sum;
   logic             add_cout;
   logic             accept;
   logic             win;

   rr_arb2 u_arb (
      .req  (req_valid),
      .prio (prio),
      .gnt  (gnt)
   );

   // Adder sees only the operand registers, never the live request inputs.
   RCA_16bit u_rca (
      .a    (op_a),
      .b    (op_b),
      .cin  (op_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Grant is offered only while idle; status flags decode the state register.
   always_comb begin
      req_ready = (state == IDLE) ? gnt : '0;
      accept    = |(req_valid & req_ready);
      win       = req_ready[1];
      rsp_valid = (state == DONE);
      busy      = (state != IDLE);
   end

   // Accept, hold operands while the ripple settles, then present the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         prio     <= 1'b0;
         op_a     <= '0;
         op_b     <= '0;
         op_cin   <= 1'b0;
         cnt      <= '0;
         rsp_id   <= 1'b0;
         rsp_sum  <= '0;
         rsp_cout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_a   <= win ? req_a[2*OP_W-1:OP_W] : req_a[OP_W-1:0];
                  op_b   <= win ? req_b[2*OP_W-1:OP_W] : req_b[OP_W-1:0];
                  op_cin <= req_cin[win];
                  rsp_id <= win;
                  cnt    <= CNT_W'(SETTLE_CYCLES - 1);
                  state  <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  rsp_sum  <= add_sum;
                  rsp_cout <= add_cout;
                  state    <= DONE;
               end
            end
            DONE: begin
               if (rsp_ready) begin
                  prio  <= ~rsp_id;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rca_share_arbiter.sv
// Self-checking bench for rca_share_arbiter against a transaction-level model.
module tb_rca_share_arbiter;

   localparam int unsigned S = 24;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [1:0]  req_cin;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [15:0] rsp_sum;
   logic        rsp_cout;
   logic        busy;

   int unsigned total = 0;
   int unsigned bad   = 0;
   logic        prio_m;

   always #5 clk = ~clk;

   rca_share_arbiter #(.SETTLE_CYCLES(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_cin   (req_cin),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b0;
      @(negedge clk);
      rst_n  = 1'b1;
      prio_m = 1'b0;
   endtask

   // One transaction; called at a negedge with the DUT idle.
   task automatic do_op(input logic [1:0] v,
                        input logic [15:0] a0, input logic [15:0] b0, input logic c0,
                        input logic [15:0] a1, input logic [15:0] b1, input logic c1,
                        input int unsigned stall, input bit keep);
      logic        w;
      logic [15:0] ea, eb;
      logic        ec;
      logic [16:0] e;
      req_valid = v;
      req_a     = {a1, a0};
      req_b     = {b1, b0};
      req_cin   = {c1, c0};
      rsp_ready = 1'b0;
      w  = (v == 2'b11) ? prio_m : v[1];
      ea = w ? a1 : a0;
      eb = w ? b1 : b0;
      ec = w ? c1 : c0;
      e  = {1'b0, ea} + {1'b0, eb} + {16'b0, ec};
      #1;
      chk("grant", 32'(req_ready), 32'(2'b01 << w));
      @(negedge clk);
      if (!keep) begin
         req_valid[w] = 1'b0;
         req_a        = $urandom;
         req_b        = $urandom;
         req_cin      = 2'($urandom);
      end
      for (int unsigned j = 0; j < S; j++) begin
         chk("settle_valid", 32'(rsp_valid), 32'd0);
         chk("settle_busy", 32'(busy), 32'd1);
         chk("settle_ready", 32'(req_ready), 32'd0);
         chk("hold_op", {15'd0, dut.op_cin, dut.op_a}, {15'd0, ec, ea});
         chk("hold_opb", 32'(dut.op_b), 32'(eb));
         if (!keep) rsp_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      rsp_ready = (stall == 0);
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_id", 32'(rsp_id), 32'(w));
      chk("rsp_result", {15'd0, rsp_cout, rsp_sum}, 32'(e));
      for (int unsigned j = 0; j < stall; j++) begin
         @(negedge clk);
         if (j == stall - 1) rsp_ready = 1'b1;
         chk("stall_valid", 32'(rsp_valid), 32'd1);
         chk("stall_busy", 32'(busy), 32'd1);
         chk("stall_ready", 32'(req_ready), 32'd0);
         chk("stall_result", {14'd0, rsp_id, rsp_cout, rsp_sum}, {14'd0, w, e});
      end
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("post_valid", 32'(rsp_valid), 32'd0);
      chk("post_busy", 32'(busy), 32'd0);
      prio_m = ~w;
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_cin   = '0;
      rsp_ready = 1'b0;
      prio_m    = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp", {14'd0, rsp_id, rsp_cout, rsp_sum}, 32'd0);
      rst_n = 1'b1;

      // carry out of the top bit
      do_op(2'b01, 16'hFFFF, 16'h0001, 1'b0, 16'h0, 16'h0, 1'b0, 0, 1'b0);

      // valid that drops before an edge is never accepted
      req_valid = 2'b01;
      #2;
      req_valid = 2'b00;
      @(negedge clk);
      chk("drop_busy", 32'(busy), 32'd0);

      // tie after reset: req0 first, req1 right after
      do_reset();
      do_op(2'b11, 16'h0102, 16'h0304, 1'b0, 16'h1234, 16'h4321, 1'b1, 0, 1'b1);
      do_op(2'b10, 16'h0102, 16'h0304, 1'b0, 16'h1234, 16'h4321, 1'b1, 0, 1'b0);

      // continuous tie alternates
      for (int unsigned k = 0; k < 4; k++)
         do_op(2'b11, 16'(k), 16'h1111, 1'b1, 16'h7FFF, 16'(k), 1'b0, 0, 1'b1);

      // consumer back-pressure
      do_op(2'b01, 16'hABCD, 16'h1234, 1'b1, 16'h0, 16'h0, 1'b0, 5, 1'b0);

      // reset in the middle of SETTLE
      req_valid = 2'b01;
      req_a     = {16'h0, 16'h1111};
      req_b     = {16'h0, 16'h2222};
      @(negedge clk);
      req_valid = 2'b00;
      repeat (10) @(negedge clk);
      chk("mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_rsp", {13'd0, rsp_valid, rsp_id, rsp_cout, rsp_sum}, 32'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      prio_m = 1'b0;
      for (int unsigned j = 0; j < S + 2; j++) begin
         chk("no_rsp", 32'(rsp_valid), 32'd0);
         @(negedge clk);
      end
      do_op(2'b10, 16'h0, 16'h0, 1'b0, 16'h8000, 16'h8000, 1'b0, 0, 1'b0);

      // random traffic
      for (int unsigned k = 0; k < 200; k++)
         do_op(2'($urandom_range(1, 3)), 16'($urandom), 16'($urandom), 1'($urandom),
               16'($urandom), 16'($urandom), 1'($urandom), $urandom_range(0, 3), 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
